// File: rtl/shift_sched_pkg.sv
// Shared types and datapath command codes for the shift_sched scheduler.
// Imported by the register sub-module and the top-level FSM.
package shift_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_LOAD = 2'b01;
    localparam logic [1:0] SR_SHR  = 2'b10;

    function automatic logic [1:0] one_hot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/shift_sched_if.sv
// Word-level client and serial-link signals of the scheduler.
// The slave modport is the scheduler's view; master is the client/link side.
interface shift_sched_if #(
    parameter int WIDTH = 8
);

    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [1:0]       gnt;
    logic [1:0]       done;
    logic [WIDTH-1:0] rx_data;
    logic             ser_out;
    logic             ser_in;
    logic             busy;
    logic [1:0]       sr_ctrl;

    modport master (
        output req, data0, data1, ser_in,
        input  gnt, done, rx_data, ser_out, busy, sr_ctrl
    );

    modport slave (
        input  req, data0, data1, ser_in,
        output gnt, done, rx_data, ser_out, busy, sr_ctrl
    );

endinterface

// File: rtl/shift_sched_sr.sv
// Shared WIDTH-bit shift register: hold, parallel load, or shift right with
// the serial input entering at the MSB. The unused command code holds.
module shift_sched_sr
    import shift_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sr_ctrl,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] sr_q
);

    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        case (sr_ctrl)
            SR_LOAD: sr_d = load_data;
            SR_SHR:  sr_d = {ser_in, sr_q[WIDTH-1:1]};
            default: sr_d = sr_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one shift register between two requesters:
// arbitrates in IDLE, then sequences load / WIDTH shifts / done.
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    shift_sched_if.slave  bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    sched_state_t     state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             winner;
    logic [1:0]       sr_ctrl;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] sr_q;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        winner = bus.req[1];
        if (bus.req == 2'b11) begin
            winner = ~last_q;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.req != 2'b00) begin
                    owner_d = winner;
                    last_d  = winner;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Moore output decode from registered state and owner.
    always_comb begin
        bus.gnt  = 2'b00;
        bus.done = 2'b00;
        bus.busy = 1'b1;
        sr_ctrl  = SR_HOLD;
        case (state_q)
            IDLE:    bus.busy = 1'b0;
            LOAD: begin
                bus.gnt = one_hot(owner_q);
                sr_ctrl = SR_LOAD;
            end
            SHIFT:   sr_ctrl = SR_SHR;
            DONE:    bus.done = one_hot(owner_q);
            default: bus.busy = 1'b1;
        endcase
    end

    assign load_word   = owner_q ? bus.data1 : bus.data0;
    assign bus.sr_ctrl = sr_ctrl;
    assign bus.ser_out = sr_q[0];
    assign bus.rx_data = sr_q;

    shift_sched_sr #(
        .WIDTH(WIDTH)
    ) u_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .sr_ctrl   (sr_ctrl),
        .load_data (load_word),
        .ser_in    (bus.ser_in),
        .sr_q      (sr_q)
    );

endmodule

// File: tb/tb_shift_sched.sv
// Self-checking bench for shift_sched: directed scenarios with literal
// expectations plus randomized traffic against a transaction-level model.
module tb_shift_sched;
    import shift_sched_pkg::*;

    localparam int WIDTH = 8;

    logic clk        = 1'b0;
    logic rst_n      = 1'b0;
    logic loopback   = 1'b0;
    logic ser_in_drv = 1'b0;
    bit   checking   = 1'b0;
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   cyc        = 0;

    shift_sched_if #(.WIDTH(WIDTH)) bus ();

    shift_sched #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.ser_in = loopback ? bus.ser_out : ser_in_drv;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: m_pos is the cycle index inside a transaction (-1 when idle,
    // 0 = grant cycle, 1..WIDTH = shift cycles, WIDTH+1 = done cycle).
    int               m_pos   = -1;
    logic             m_owner = 1'b0;
    logic             m_last  = 1'b1;
    logic [WIDTH-1:0] m_tx    = '0;
    logic [WIDTH-1:0] m_rx    = '0;
    int               m_k     = 0;
    logic [1:0]       s_req   = '0;
    logic [WIDTH-1:0] s_d0    = '0;
    logic [WIDTH-1:0] s_d1    = '0;
    logic             s_ser   = 1'b0;

    function automatic logic [WIDTH-1:0] exp_reg();
        return (m_tx >> m_k) | (m_rx << (WIDTH - m_k));
    endfunction

    function automatic logic exp_ser();
        logic [WIDTH-1:0] r;
        r = exp_reg();
        return r[0];
    endfunction

    function automatic logic [1:0] exp_pulse(input bit active, input logic who);
        if (!active) return 2'b00;
        return who ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] exp_ctrl();
        if (m_pos == 0) return 2'b01;
        if (m_pos >= 1 && m_pos <= WIDTH) return 2'b10;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos   <= -1;
            m_owner <= 1'b0;
            m_last  <= 1'b1;
            m_tx    <= '0;
            m_rx    <= '0;
            m_k     <= 0;
        end else if (m_pos < 0) begin
            if (s_req != 2'b00) begin
                m_owner <= (s_req == 2'b11) ? !m_last : s_req[1];
                m_last  <= (s_req == 2'b11) ? !m_last : s_req[1];
                m_pos   <= 0;
            end
        end else if (m_pos == 0) begin
            m_tx  <= m_owner ? s_d1 : s_d0;
            m_rx  <= '0;
            m_k   <= 0;
            m_pos <= 1;
        end else if (m_pos <= WIDTH) begin
            m_rx[m_k] <= s_ser;
            m_k       <= m_k + 1;
            m_pos     <= m_pos + 1;
        end else begin
            m_pos <= -1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("gnt",     32'(bus.gnt),     32'(exp_pulse(m_pos == 0, m_owner)));
            checkOutput("done",    32'(bus.done),    32'(exp_pulse(m_pos == WIDTH + 1, m_owner)));
            checkOutput("busy",    32'(bus.busy),    32'(m_pos >= 0));
            checkOutput("sr_ctrl", 32'(bus.sr_ctrl), 32'(exp_ctrl()));
            checkOutput("ser_out", 32'(bus.ser_out), 32'(exp_ser()));
            checkOutput("rx_data", 32'(bus.rx_data), 32'(exp_reg()));
        end
        s_req <= bus.req;
        s_d0  <= bus.data0;
        s_d1  <= bus.data1;
        s_ser <= loopback ? exp_ser() : ser_in_drv;
    end

    task automatic applyStimulus(input logic [1:0] r, input logic [WIDTH-1:0] d0,
                                 input logic [WIDTH-1:0] d1, input logic lb);
        bus.req   = r;
        bus.data0 = d0;
        bus.data1 = d1;
        loopback  = lb;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    // Bounded wait for a non-zero gnt (use_done=0) or done (use_done=1) pulse.
    task automatic waitPulse(input bit use_done, input int budget, input string name,
                             output logic [1:0] v, output int at);
        v  = 2'b00;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((use_done ? bus.done : bus.gnt) != 2'b00) begin
                v  = use_done ? bus.done : bus.gnt;
                at = cyc;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s timeout: got no pulse, expected one within %0d cycles", name, budget);
    endtask

    bit         lb_seq [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit         rx_seq [8] = '{1, 1, 0, 0, 0, 0, 0, 1};

    initial begin
        logic [1:0] v;
        int         at, at_prev;
        bit         seen_gnt, found;

        applyStimulus(2'b00, '0, '0, 1'b0);
        @(posedge clk);
        #2;
        checking = 1'b1;
        @(negedge clk);
        checkOutput("init_busy",    32'(bus.busy),    32'd0);
        checkOutput("init_rx_data", 32'(bus.rx_data), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Loopback of 8'hA5 from requester 0.
        applyStimulus(2'b01, 8'hA5, 8'h00, 1'b1);
        nextCycle();
        @(negedge clk);
        checkOutput("lb_gnt", 32'(bus.gnt), 32'h1);
        nextCycle();
        applyStimulus(2'b00, 8'hA5, 8'h00, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("lb_ser_seq", 32'(bus.ser_out), 32'(lb_seq[k]));
            @(posedge clk);
        end
        @(negedge clk);
        checkOutput("lb_done",    32'(bus.done),    32'h1);
        checkOutput("lb_rx_data", 32'(bus.rx_data), 32'hA5);
        checkOutput("lb_model",   32'(exp_reg()),   32'hA5);
        nextCycle();

        // External receive into requester 1.
        applyStimulus(2'b10, 8'h00, 8'h00, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(2'b00, 8'h00, 8'h00, 1'b0);
        ser_in_drv = rx_seq[0];
        for (int k = 1; k < 8; k++) begin
            nextCycle();
            ser_in_drv = rx_seq[k];
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput("ext_done",    32'(bus.done),    32'h2);
        checkOutput("ext_rx_data", 32'(bus.rx_data), 32'h83);
        checkOutput("ext_model",   32'(exp_reg()),   32'h83);
        nextCycle();

        // Continuous tie: grants alternate with one IDLE cycle between.
        applyStimulus(2'b11, 8'h11, 8'h22, 1'b1);
        waitPulse(1'b0, 4, "arb_gnt0", v, at);
        checkOutput("arb_gnt0", 32'(v), 32'h1);
        waitPulse(1'b1, 12, "arb_done0", v, at_prev);
        checkOutput("arb_rx0", 32'(bus.rx_data), 32'h11);
        waitPulse(1'b0, 4, "arb_gnt1", v, at);
        checkOutput("arb_gnt1", 32'(v), 32'h2);
        checkOutput("arb_gap1", 32'(at - at_prev), 32'd2);
        waitPulse(1'b1, 12, "arb_done1", v, at_prev);
        checkOutput("arb_rx1", 32'(bus.rx_data), 32'h22);
        waitPulse(1'b0, 4, "arb_gnt2", v, at);
        checkOutput("arb_gnt2", 32'(v), 32'h1);
        checkOutput("arb_gap2", 32'(at - at_prev), 32'd2);
        nextCycle();
        applyStimulus(2'b00, 8'h11, 8'h22, 1'b1);
        waitPulse(1'b1, 12, "arb_done2", v, at);
        nextCycle();

        // Request from 1 raised while 0 is shifting stays blocked.
        applyStimulus(2'b01, 8'h5A, 8'h77, 1'b1);
        waitPulse(1'b0, 4, "blk_gnt0", v, at);
        checkOutput("blk_gnt0", 32'(v), 32'h1);
        nextCycle();
        applyStimulus(2'b00, 8'h5A, 8'h77, 1'b1);
        repeat (3) nextCycle();
        applyStimulus(2'b10, 8'h5A, 8'h77, 1'b1);
        seen_gnt = 1'b0;
        found    = 1'b0;
        at_prev  = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) seen_gnt = 1'b1;
            if (bus.done != 2'b00) begin
                found   = 1'b1;
                at_prev = cyc;
                checkOutput("blk_done0", 32'(bus.done), 32'h1);
            end
        end
        checkOutput("blk_done_seen",    32'(found),    32'd1);
        checkOutput("blk_no_early_gnt", 32'(seen_gnt), 32'd0);
        waitPulse(1'b0, 6, "blk_gnt1", v, at);
        checkOutput("blk_gnt1", 32'(v), 32'h2);
        checkOutput("blk_gap",  32'(at - at_prev), 32'd2);
        nextCycle();
        applyStimulus(2'b00, 8'h5A, 8'h77, 1'b1);
        waitPulse(1'b1, 12, "blk_done1", v, at);
        checkOutput("blk_rx1", 32'(bus.rx_data), 32'h77);
        nextCycle();

        // Request withdrawn in the LOAD cycle still completes.
        applyStimulus(2'b01, 8'h3C, 8'h00, 1'b1);
        nextCycle();
        applyStimulus(2'b00, 8'h3C, 8'h00, 1'b1);
        waitPulse(1'b1, 14, "wd_done", v, at);
        checkOutput("wd_done",    32'(v),           32'h1);
        checkOutput("wd_rx_data", 32'(bus.rx_data), 32'h3C);
        nextCycle();

        // Reset in the middle of SHIFT with every input active.
        applyStimulus(2'b11, 8'hFF, 8'hFF, 1'b0);
        ser_in_drv = 1'b1;
        waitPulse(1'b0, 4, "rst_gnt", v, at);
        repeat (4) nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_gnt",     32'(bus.gnt),     32'd0);
        checkOutput("rst_done",    32'(bus.done),    32'd0);
        checkOutput("rst_busy",    32'(bus.busy),    32'd0);
        checkOutput("rst_sr_ctrl", 32'(bus.sr_ctrl), 32'd0);
        checkOutput("rst_ser_out", 32'(bus.ser_out), 32'd0);
        checkOutput("rst_rx_data", 32'(bus.rx_data), 32'd0);
        checkOutput("rst_state",   32'(dut.state_q), 32'(IDLE));
        repeat (2) nextCycle();
        applyStimulus(2'b00, 8'hFF, 8'hFF, 1'b0);
        rst_n = 1'b1;
        seen_gnt = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done != 2'b00) seen_gnt = 1'b1;
        end
        checkOutput("rst_no_done", 32'(seen_gnt), 32'd0);
        nextCycle();
        applyStimulus(2'b11, 8'hC3, 8'h3C, 1'b1);
        waitPulse(1'b0, 4, "rst_first_gnt", v, at);
        checkOutput("rst_first_gnt", 32'(v), 32'h1);
        nextCycle();
        applyStimulus(2'b00, 8'hC3, 8'h3C, 1'b1);
        waitPulse(1'b1, 12, "rst_next_done", v, at);
        checkOutput("rst_next_rx", 32'(bus.rx_data), 32'hC3);
        nextCycle();

        // Randomized traffic, occasional resets, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) loopback = ~loopback;
            applyStimulus(2'($urandom_range(0, 3)), WIDTH'($urandom), WIDTH'($urandom), loopback);
            ser_in_drv = 1'($urandom_range(0, 1));
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            nextCycle();
        end
        rst_n = 1'b1;
        applyStimulus(2'b00, '0, '0, 1'b0);
        repeat (WIDTH + 4) nextCycle();

        checking = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
